mist_uart_rx: RTL
=================

Name: mist_uart_rx

Overview:
- Parametrised serial receiver, successor to the fixed 8N1/115200 console receiver.
- Configurable baud rate, data width, parity and stop bits; double-flop input synchronisation; false-start rejection.
- Framing, parity and overrun detection; received words buffered in a first-word-fall-through FIFO with a valid/ready handshake.
- Sits between the external serial pin and the IO-controller / CPU peripheral bus.

Parameters:
- CLKFREQ, 100, system clock in MHz.
- BAUD, 115200, line rate in bit/s. TICKS = (CLKFREQ*1000000)/BAUD, integer division (868 at defaults).
- DATABITS, 8, data bits per frame; legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOPBITS, 1, stop bits checked; legal 1 or 2.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ser_in  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  DATABITS  head FIFO word, LSB = first bit received.
- rx_valid  out  1  FIFO not empty; rx_data is valid.
- rx_ready  in  1  consumer accepts head word.
- fifo_level  out  log2(FIFO_DEPTH)+1  entries currently stored.
- framing_err  out  1  sticky: a stop bit was sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: a good word was dropped because the FIFO was full.
- err_clr  in  1  single-cycle clear of all three sticky flags.

Behaviour:
- Reset (async assert, sync release): sync flops = 1, state IDLE, FIFO empty, rx_valid = 0, fifo_level = 0, all error flags = 0, rx_data = 0.
- Synchroniser: two flops on ser_in. Every reference below to "line" means the synchronised value.
- States: IDLE, START, DATA, PAR, STOP, BREAK. One bit counter, down-counting tick counter (width >= clog2(TICKS) + 1).
- IDLE: line low → load TICKS/2, enter START.
- START: at count 0, sample the line.
  - Line high → false start, return to IDLE. No flags, no push.
  - Line low → load TICKS, enter DATA.
- DATA: sample every TICKS at mid-bit, shift in LSB-first, DATABITS samples. Then go to PAR if PARITY != 0, else STOP.
- PAR: sample one bit. Odd parity = XOR of data and parity bit equals 1; even parity = that XOR equals 0. On mismatch, mark the frame bad_parity.
- STOP: sample STOPBITS bits, each TICKS apart.
  - Any stop sample low → set framing_err, discard the frame, go to BREAK.
  - All high → if bad_parity, set parity_err and discard; else push the word. Return to IDLE in the same cycle as the last stop sample (mid-bit), so a back-to-back start bit is caught.
- BREAK: wait for line high, then IDLE. A line held low gives exactly one framing event.
- FIFO: push in the final stop-sample cycle. rx_valid rises the following clock when the FIFO was empty.
  - Pop on rx_valid & rx_ready.
  - Full and push, no pop → word dropped, overrun set, contents unchanged.
  - Full and push with pop in the same cycle → both accepted, level unchanged, no overrun.
  - Empty and push with rx_ready high → word stored; it is not popped that cycle.
- fifo_level: +1 on push, -1 on pop, unchanged on both or neither.
- Sticky flags: a set event has priority over err_clr in the same cycle.
- rx_data: reflects the FIFO head. Undefined value is permitted only while rx_valid = 0; hold it stable while rx_valid = 1 and no pop occurs.
- Reset mid-frame: partial frame discarded, FIFO cleared, receiver rearmed on release. A low line at release is treated as a new start.

Test Plan:
- Defaults, send 0x55 8N1 → rx_data = 0x55 and rx_valid = 1 within 9.5 × 868 ± 4 clocks of the start edge; fifo_level = 1; pop with rx_ready → level 0.
- 200-clock low glitch on idle line → no push, no flags, next frame 0x3C received correctly.
- 0xA3 with stop bit forced low, line then held low for 20 bit times → framing_err = 1 (single event), no push; after line returns high, 0x81 received correctly.
- PARITY = 2: send 0x07 with parity bit 0 → parity_err = 1, no push. Send 0x07 with parity bit 1 → push 0x07. err_clr → parity_err = 0.
- DATABITS = 9, STOPBITS = 2: send 0x1A5 → rx_data = 0x1A5. Second stop bit low → framing_err = 1, no push.
- rx_ready = 0, send 17 bytes 0x00..0x10 → level 16, overrun = 1, pops return 0x00..0x0F in order. Also check a push coinciding with a pop while full sets no overrun, and a reset asserted mid-frame clears everything and the next frame is received.

Source files
------------

// File: rtl/mist_uart_rx.sv
`timescale 1ns/1ps
// mist_uart_rx: parametrised asynchronous serial receiver.
// The line is double-flopped, each frame is sampled at mid-bit, and good
// words are stored in a first-word-fall-through FIFO. Framing errors,
// parity errors and overruns are reported on sticky flags.
//
// Handshake: rx_valid is high whenever the FIFO holds a word, and rx_data
// then shows the head word. A word is consumed on every clock edge where
// rx_valid and rx_ready are both high. While rx_valid is high and no pop
// happens, rx_data holds its value.
module mist_uart_rx #(
  parameter int CLKFREQ    = 100,
  parameter int BAUD       = 115200,
  parameter int DATABITS   = 8,
  parameter int PARITY     = 0,
  parameter int STOPBITS   = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_in,
  output logic [DATABITS-1:0]           rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [2:0]                    state_dbg
);

  localparam int TICKS = (CLKFREQ * 1000000) / BAUD;
  localparam int CW    = $clog2(TICKS) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  // The IDLE cycle that detects the falling edge already counts as one
  // tick of the half-bit delay, and a reload in the sample cycle costs one
  // more, so both loads are one short of the nominal tick count.
  localparam logic [CW-1:0] HALF_LOAD = CW'(TICKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(TICKS - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATABITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOPBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  logic [1:0]          sync_q;
  logic                line;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [DATABITS-1:0] shreg_q, shreg_d;
  logic                par_acc_q, par_acc_d;
  logic                bad_par_q, bad_par_d;
  logic                tick;
  logic                push, ferr_set, perr_set;

  logic [DATABITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       count_q;
  logic                pop, full, wr_en, ovr_set;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], ser_in};
  end

  assign line = sync_q[1];
  assign tick = (cnt_q == '0);

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_acc_q <= 1'b0;
      bad_par_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_acc_q <= par_acc_d;
      bad_par_q <= bad_par_d;
    end
  end

  // Next-state logic: mid-bit sampling, shifting, parity and stop checks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_acc_d = par_acc_q;
    bad_par_d = bad_par_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!line) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (line) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = FULL_LOAD;
            bit_d     = '0;
            par_acc_d = 1'b0;
            bad_par_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d   = {line, shreg_q[DATABITS-1:1]};
          par_acc_d = par_acc_q ^ line;
          cnt_d     = FULL_LOAD;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          // Odd parity wants the XOR over data and parity bit to be 1.
          bad_par_d = (PARITY == 1) ? ~(par_acc_q ^ line) : (par_acc_q ^ line);
          cnt_d     = FULL_LOAD;
          bit_d     = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!line) begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end else if (bit_q == LAST_STOP) begin
            // Leave at mid stop bit so a back-to-back start edge is seen.
            state_d = S_IDLE;
            if (bad_par_q) perr_set = 1'b1;
            else           push     = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            cnt_d = FULL_LOAD;
          end
        end
      end
      S_BREAK: begin
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

  // FIFO control: a pop frees a slot for a push in the same cycle.
  assign rx_valid   = (count_q != '0);
  assign pop        = rx_valid & rx_ready;
  assign full       = (count_q == LW'(FIFO_DEPTH));
  assign wr_en      = push & (~full | pop);
  assign ovr_set    = push & full & ~pop;
  assign fifo_level = count_q;
  assign rx_data    = rx_valid ? mem[rd_ptr_q] : '0;

  // FIFO storage; contents need no reset because rx_data is gated by rx_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shreg_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a set event wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (ferr_set)     framing_err <= 1'b1;
      else if (err_clr) framing_err <= 1'b0;
      if (perr_set)     parity_err  <= 1'b1;
      else if (err_clr) parity_err  <= 1'b0;
      if (ovr_set)      overrun     <= 1'b1;
      else if (err_clr) overrun     <= 1'b0;
    end
  end

endmodule
